decode_ctrl: RTL and testbench
==============================

# decode_ctrl

Instruction-decode stage controller. Holds the IF/ID pipeline register, drives the decoder's `instruction` input, and issues decoded instructions to execute over a valid/ready handshake. Detects load-use hazards against one outstanding load and stalls issue until the load completes. Handles branch/jump flush. Sits between fetch and the decoder/execute boundary of the rv32 core.

## Interface
Parameters:
- `XLEN`, default 32: PC width.
- `CNT_W`, default 16: stall counter width; used only with `DECODE_CTRL_PERF_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  controller accepts the fetch beat.
- `if_instr`  in  32  fetched instruction.
- `if_pc`  in  XLEN  PC of `if_instr`.
- `id_instr`  out  32  registered instruction; feeds the decoder.
- `id_pc`  out  XLEN  registered PC.
- `ex_valid`  out  1  decoded instruction offered to execute.
- `ex_ready`  in  1  execute accepts.
- `flush`  in  1  taken branch/jump; kill the held instruction.
- `mem_load_done`  in  1  single-cycle pulse: the outstanding load has written back.
- `hazard`  out  1  a load-use stall is active this cycle.
- `stall_cnt`  out  CNT_W  count of hazard cycles; present only with `DECODE_CTRL_PERF_EN`.

## Operation
- FSM states: EMPTY, FULL, HAZARD. Reset state is EMPTY.
- Reset values: `id_instr` = 32'h0000_0013 (NOP), `id_pc` = 0, load-pending flag = 0, pending rd = 0, `stall_cnt` = 0.
- Source-register use is selected by opcode `id_instr[6:0]`:
  - 0110011, 0100011, 1100011: use rs1 and rs2.
  - 0000011, 0010011, 1100111: use rs1 only.
  - 0110111, 0010111, 1101111: use no source registers.
  - Any other opcode uses no source registers and issues as-is.
- `raw` = load pending AND pending rd ≠ 0 AND a used rs equals pending rd.
- `raw` is also asserted when `id_instr` is itself a load while a load is pending. Only one load may be outstanding.
- `hazard` = (state ≠ EMPTY) AND `raw`.
- `ex_valid` = (state ≠ EMPTY) AND NOT `hazard` AND NOT `flush`.
- `issue` = `ex_valid` AND `ex_ready`.
- `if_ready` = NOT `flush` AND (state = EMPTY OR `issue`).
- `accept` = `if_valid` AND `if_ready`.
- Transitions:
  - EMPTY → FULL on `accept`.
  - FULL/HAZARD → FULL on `issue` AND `accept`.
  - FULL/HAZARD → EMPTY on `issue` without `accept`.
  - FULL ↔ HAZARD follows `raw` while not issuing.
  - Any state → EMPTY on `flush`.
- On `accept`, load `id_instr`/`id_pc` from `if_instr`/`if_pc`. They hold otherwise, including while stalled.
- Load tracking:
  - On `issue` of an opcode-0000011 instruction, set the pending flag and store rd = `id_instr[11:7]`.
  - `mem_load_done` clears the flag.
- Simultaneous events:
  - `flush` beats `accept`: the beat is dropped.
  - Issue of a new load on the same cycle as `mem_load_done`: the set wins.
  - `flush` does not clear the pending-load flag.
  - `mem_load_done` with no load pending is ignored.

## Timing
- Accept-to-offer latency is one cycle: a beat accepted at edge N gives `ex_valid` high after edge N.
- Full throughput is one instruction per cycle when `ex_ready` is held high and there are no hazards.
- `ex_valid`, `if_ready` and `hazard` are combinational from registered state and the `flush`/`ex_ready` inputs. No combinational path exists from `if_valid` to `ex_valid`.
- Load-use stall ends the cycle after the `mem_load_done` pulse. Pending state is registered, so `raw` drops one cycle later.
- Once `ex_valid` is high it stays high, with `id_instr` stable, until `issue` or `flush`.
- Reset asserted mid-operation immediately forces EMPTY; all outputs return to their reset values.

## Configuration
- `DECODE_CTRL_PERF_EN` defined:
  - `stall_cnt` port exists.
  - The counter increments on every cycle `hazard` = 1 and saturates at all-ones.
  - `flush` does not clear it; only `rst` does.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Stream: `ex_ready` = 1; feed ADDI x1 (0x00100093), ADD x2,x1,x1 (0x00108133), LUI x3 (0x000011B7) back-to-back -> `ex_valid` high on 3 consecutive cycles, with `id_instr` in order and `hazard` never high.
- Load-use: issue LW x5,0(x0) (0x00002283), then ADD x6,x5,x0 (0x00028333) -> `hazard` = 1 and `ex_valid` = 0 until `mem_load_done`; ADD issues on the cycle after the pulse.
- rd = x0 and non-users: LW x0 (0x00002003), then ADD using x0 -> no stall. LW x7, then JAL x1 (0x000000EF) -> no stall.
- Backpressure: `ex_ready` = 0 for 4 cycles with `if_valid` = 1 -> `if_ready` = 0, and `id_instr`/`id_pc` stay stable. On release, the next beat is accepted the same cycle as issue.
- Flush: FULL with `if_valid` = 1 and `flush` = 1 -> `ex_valid` = 0, `if_ready` = 0, state EMPTY next cycle. A pending load survives and still stalls a dependent instruction afterwards.
- Perf/reset: with `DECODE_CTRL_PERF_EN`, a 3-cycle hazard gives `stall_cnt` = 3. Asserting `rst` mid-stall gives `stall_cnt` = 0, `ex_valid` = 0, `id_instr` = 0x00000013 asynchronously.

Source files
------------

// File: rtl/decode_ctrl_if.sv
// Fetch/decode/execute boundary bundle for the decode-stage controller.
// master: the controller side (decode_ctrl); slave: the surrounding pipeline.
// Signals: fetch beat (if_*), held instruction (id_*), issue handshake (ex_*),
// flush, load-writeback pulse and the load-use hazard indication.
interface decode_ctrl_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            ex_valid;
    logic            ex_ready;
    logic            flush;
    logic            mem_load_done;
    logic            hazard;

    modport master (
        input  if_valid, if_instr, if_pc, ex_ready, flush, mem_load_done,
        output if_ready, id_instr, id_pc, ex_valid, hazard
    );

    modport slave (
        output if_valid, if_instr, if_pc, ex_ready, flush, mem_load_done,
        input  if_ready, id_instr, id_pc, ex_valid, hazard
    );
endinterface

// File: rtl/decode_ctrl.sv
// Decode-stage controller: IF/ID register, load-use stall against one outstanding load, flush.
// Latency: beat accepted at edge N is offered to execute right after edge N (1 cycle).
// Backpressure: if_ready only when empty or issuing this cycle; stalls hold id_instr/id_pc.
//
// Ports: clk, rst (async, active-high); bus (decode_ctrl_if.master) carries the fetch beat,
// the held instruction to the decoder, the execute handshake, flush, mem_load_done, hazard.
// Optional feature macro DECODE_CTRL_PERF_EN adds output stall_cnt[CNT_W-1:0], a saturating
// count of hazard cycles cleared only by rst.
module decode_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    decode_ctrl_if.master     bus
`ifdef DECODE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        HAZARD = 2'd2
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            ld_pend;
    logic [4:0]      ld_rd;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            raw;
    logic            hazard;
    logic            ex_valid;
    logic            issue;
    logic            if_ready;
    logic            accept;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // Source-register usage by opcode; anything unrecognised uses none.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_REG, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A second load behind a pending one also stalls: only one may be outstanding.
    assign raw = ld_pend &&
                 (((ld_rd != 5'd0) &&
                   ((use_rs1 && (rs1 == ld_rd)) || (use_rs2 && (rs2 == ld_rd)))) ||
                  (opcode == OP_LOAD));

    assign hazard   = (state != EMPTY) && raw;
    assign ex_valid = (state != EMPTY) && !hazard && !bus.flush;
    assign issue    = ex_valid && bus.ex_ready;
    assign if_ready = !bus.flush && ((state == EMPTY) || issue);
    assign accept   = bus.if_valid && if_ready;

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:       if (accept) state_nxt = FULL;
                FULL, HAZARD: begin
                    if (issue)    state_nxt = accept ? FULL : EMPTY;
                    else if (raw) state_nxt = HAZARD;
                    else          state_nxt = FULL;
                end
                default:     state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // IF/ID register: loads only on accept, so it holds through stalls and backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr <= NOP;
            id_pc    <= '0;
        end else if (accept) begin
            id_instr <= bus.if_instr;
            id_pc    <= bus.if_pc;
        end
    end

    // Issuing a load takes priority over a coincident writeback pulse; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_pend <= 1'b0;
            ld_rd   <= 5'd0;
        end else if (issue && (opcode == OP_LOAD)) begin
            ld_pend <= 1'b1;
            ld_rd   <= id_instr[11:7];
        end else if (bus.mem_load_done) begin
            ld_pend <= 1'b0;
        end
    end

`ifdef DECODE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    // Counter width only matters when the counter exists.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    assign bus.if_ready = if_ready;
    assign bus.id_instr = id_instr;
    assign bus.id_pc    = id_pc;
    assign bus.ex_valid = ex_valid;
    assign bus.hazard   = hazard;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: stream, load-use stall, rd=x0/non-user, backpressure,
// flush with surviving pending load, and async reset mid-stall (with stall counter if built in).
module tb_decode_ctrl;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1    = 32'h0010_0093;
    localparam logic [31:0] ADD_X2     = 32'h0010_8133;
    localparam logic [31:0] LUI_X3     = 32'h0000_11B7;
    localparam logic [31:0] LW_X5      = 32'h0000_2283;
    localparam logic [31:0] ADD_X6_X5  = 32'h0002_8333;
    localparam logic [31:0] LW_X0      = 32'h0000_2003;
    localparam logic [31:0] ADD_X6_X0  = 32'h0000_0333;
    localparam logic [31:0] LW_X7      = 32'h0000_2383;
    localparam logic [31:0] JAL_X1     = 32'h0000_00EF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_ctrl_if #(.XLEN(32)) bus();

`ifdef DECODE_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    decode_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );
`else
    decode_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic ld);
        bus.if_valid      = v;
        bus.if_instr      = ins;
        bus.if_pc         = pc;
        bus.ex_ready      = rdy;
        bus.flush         = fl;
        bus.mem_load_done = ld;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%0b exp=0", bus.ex_valid); end
        total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL rst_if_ready got=%0b exp=1", bus.if_ready); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%0b exp=0", bus.hazard); end
        total++; if (bus.id_instr !== NOP) begin bad++; $display("FAIL rst_id_instr got=%h exp=%h", bus.id_instr, NOP); end
        total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", bus.id_pc); end
`ifdef DECODE_CTRL_PERF_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [31:0] ins [3];
        logic [31:0] pcs [3];
        ins[0] = ADDI_X1; ins[1] = ADD_X2; ins[2] = LUI_X3;
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        drive(1'b1, ins[0], pcs[0], 1'b1, 1'b0, 1'b0);
        total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL stream_first_rdy got=%0b exp=1", bus.if_ready); end
        step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, ins[i+1], pcs[i+1], 1'b1, 1'b0, 1'b0);
            else       drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL stream_vld%0d got=%0b exp=1", i, bus.ex_valid); end
            total++; if (bus.id_instr !== ins[i]) begin bad++; $display("FAIL stream_instr%0d got=%h exp=%h", i, bus.id_instr, ins[i]); end
            total++; if (bus.id_pc !== pcs[i]) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, bus.id_pc, pcs[i]); end
            total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL stream_hazard%0d got=%0b exp=0", i, bus.hazard); end
            total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL stream_rdy%0d got=%0b exp=1", i, bus.if_ready); end
            step();
        end
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", bus.ex_valid); end
    endtask

    task automatic test_load_use();
        drive(1'b1, LW_X5, 32'h200, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, ADD_X6_X5, 32'h204, 1'b1, 1'b0, 1'b0);
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_lw_issue got=%0b exp=1", bus.ex_valid); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL lu_hazard%0d got=%0b exp=1", i, bus.hazard); end
            total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_vld%0d got=%0b exp=0", i, bus.ex_valid); end
            total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL lu_rdy%0d got=%0b exp=0", i, bus.if_ready); end
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL lu_pulse_hazard got=%0b exp=1", bus.hazard); end
        step();
        exp_cnt += 4;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL lu_release_hazard got=%0b exp=0", bus.hazard); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_release_vld got=%0b exp=1", bus.ex_valid); end
        total++; if (bus.id_instr !== ADD_X6_X5) begin bad++; $display("FAIL lu_release_instr got=%h exp=%h", bus.id_instr, ADD_X6_X5); end
`ifdef DECODE_CTRL_PERF_EN
        total++; if (stall_cnt !== exp_cnt[15:0]) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
`endif
        step();
    endtask

    task automatic test_rd_x0_nonuser();
        drive(1'b1, LW_X0, 32'h300, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, ADD_X6_X0, 32'h304, 1'b1, 1'b0, 1'b0);
        step();
        // Clear the x0 load on the same cycle the ADD issues and LW x7 is taken.
        drive(1'b1, LW_X7, 32'h308, 1'b1, 1'b0, 1'b1);
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL x0_hazard got=%0b exp=0", bus.hazard); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL x0_vld got=%0b exp=1", bus.ex_valid); end
        step();
        drive(1'b1, JAL_X1, 32'h30C, 1'b1, 1'b0, 1'b0);
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lw7_vld got=%0b exp=1", bus.ex_valid); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL jal_hazard got=%0b exp=0", bus.hazard); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL jal_vld got=%0b exp=1", bus.ex_valid); end
        total++; if (bus.id_instr !== JAL_X1) begin bad++; $display("FAIL jal_instr got=%h exp=%h", bus.id_instr, JAL_X1); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        drive(1'b1, ADDI_X1, 32'h400, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, LUI_X3, 32'h404, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL bp_rdy%0d got=%0b exp=0", i, bus.if_ready); end
            total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL bp_vld%0d got=%0b exp=1", i, bus.ex_valid); end
            total++; if (bus.id_instr !== ADDI_X1) begin bad++; $display("FAIL bp_instr%0d got=%h exp=%h", i, bus.id_instr, ADDI_X1); end
            total++; if (bus.id_pc !== 32'h400) begin bad++; $display("FAIL bp_pc%0d got=%h exp=400", i, bus.id_pc); end
            step();
        end
        drive(1'b1, LUI_X3, 32'h404, 1'b1, 1'b0, 1'b0);
        total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%0b exp=1", bus.if_ready); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.id_instr !== LUI_X3) begin bad++; $display("FAIL bp_next_instr got=%h exp=%h", bus.id_instr, LUI_X3); end
        total++; if (bus.id_pc !== 32'h404) begin bad++; $display("FAIL bp_next_pc got=%h exp=404", bus.id_pc); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL bp_next_vld got=%0b exp=1", bus.ex_valid); end
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, LW_X5, 32'h500, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, ADDI_X1, 32'h504, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, ADD_X6_X5, 32'h508, 1'b1, 1'b1, 1'b0);
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_vld got=%0b exp=0", bus.ex_valid); end
        total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL fl_rdy got=%0b exp=0", bus.if_ready); end
        step();
        drive(1'b1, ADD_X6_X5, 32'h508, 1'b1, 1'b0, 1'b0);
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_empty_vld got=%0b exp=0", bus.ex_valid); end
        total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL fl_empty_rdy got=%0b exp=1", bus.if_ready); end
        total++; if (bus.id_pc !== 32'h504) begin bad++; $display("FAIL fl_dropped_pc got=%h exp=504", bus.id_pc); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL fl_pend_hazard got=%0b exp=1", bus.hazard); end
        total++; if (bus.id_pc !== 32'h508) begin bad++; $display("FAIL fl_pend_pc got=%h exp=508", bus.id_pc); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        exp_cnt += 2;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL fl_release_vld got=%0b exp=1", bus.ex_valid); end
        step();
    endtask

    task automatic test_perf_reset();
        drive(1'b1, LW_X5, 32'h600, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, ADD_X6_X5, 32'h604, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL pr_hazard%0d got=%0b exp=1", i, bus.hazard); end
            step();
        end
        exp_cnt += 3;
`ifdef DECODE_CTRL_PERF_EN
        total++; if (stall_cnt !== exp_cnt[15:0]) begin bad++; $display("FAIL pr_stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
`endif
        // Asynchronous reset in the middle of the cycle, away from any edge.
        #1;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL pr_rst_vld got=%0b exp=0", bus.ex_valid); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL pr_rst_hazard got=%0b exp=0", bus.hazard); end
        total++; if (bus.id_instr !== NOP) begin bad++; $display("FAIL pr_rst_instr got=%h exp=%h", bus.id_instr, NOP); end
        total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL pr_rst_pc got=%h exp=0", bus.id_pc); end
`ifdef DECODE_CTRL_PERF_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL pr_rst_cnt got=%0d exp=0", stall_cnt); end
`endif
        step();
        rst = 1'b0;
        drive(1'b1, ADD_X6_X5, 32'h700, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL pr_post_hazard got=%0b exp=0", bus.hazard); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL pr_post_vld got=%0b exp=1", bus.ex_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_rd_x0_nonuser();
        test_backpressure();
        test_flush();
        test_perf_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
